// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle fast path for divide special cases.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             reg_write
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hi, hi_n;
  logic [WIDTH-1:0] lo, lo_n;
  logic [WIDTH-1:0] opnd, opnd_n;
  logic [2:0]       fn, fn_n;
  logic             neg, neg_n;
  logic             busy_n, done_n, reg_write_n;
  logic [WIDTH-1:0] result_n;
  logic [4:0]       rd_out_n;

  // Operand decode at acceptance
  logic             sign_a, sign_b, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_val;

  always_comb begin
    sign_a   = !((funct3 == 3'd3) || (funct3[2] && funct3[0]));
    sign_b   = sign_a && (funct3 != 3'd2);
    a_neg    = sign_a && op_a[WIDTH-1];
    b_neg    = sign_b && op_b[WIDTH-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    if (div_zero) special_val = funct3[1] ? op_a : '1;
    else          special_val = funct3[1] ? '0 : op_a;
  end

  // One iteration step plus sign fix-up of the finished value
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_val;

  always_comb begin
    mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
    rem_sh  = {hi, lo[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opnd};
    if (!fn[2]) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      step_hi = rem_ge ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], rem_ge};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -step_lo : step_lo;
    rem_fix  = neg ? -step_hi : step_hi;
    case (fn)
      3'd0:          final_val = prod_fix[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:          final_val = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:    final_val = quo_fix;
      default:       final_val = rem_fix;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hi_n        = hi;
    lo_n        = lo;
    opnd_n      = opnd;
    fn_n        = fn;
    neg_n       = neg;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    reg_write_n = 1'b0;
    result_n    = result;
    rd_out_n    = rd_out;
    case (state)
      S_IDLE: begin
        if (start) begin
          fn_n     = funct3;
          rd_out_n = rd_in;
          busy_n   = 1'b1;
          if (div_zero || div_ovf) begin
            state_n     = S_DONE;
            done_n      = 1'b1;
            result_n    = special_val;
            reg_write_n = (rd_in != 5'd0);
          end else begin
            state_n = S_CALC;
            cnt_n   = CW'(WIDTH - 1);
            hi_n    = '0;
            lo_n    = funct3[2] ? a_mag : b_mag;
            opnd_n  = funct3[2] ? b_mag : a_mag;
            neg_n   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          end
        end
      end
      S_CALC: begin
        busy_n = 1'b1;
        hi_n   = step_hi;
        lo_n   = step_lo;
        cnt_n  = cnt - CW'(1);
        if (cnt == '0) begin
          state_n     = S_DONE;
          done_n      = 1'b1;
          result_n    = final_val;
          reg_write_n = (rd_out != 5'd0);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      fn        <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hi        <= hi_n;
      lo        <= lo_n;
      opnd      <= opnd_n;
      fn        <= fn_n;
      neg       <= neg_n;
      busy      <= busy_n;
      done      <= done_n;
      reg_write <= reg_write_n;
      result    <= result_n;
      rd_out    <= rd_out_n;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  // Reference result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; pu = ua / ub; return pu[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (fn[2] && b == 0) return 1;
    if ((fn == 3'd4 || fn == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one op from an idle cycle; report observations at done and one cycle after.
  // poke > 0 pulses start (with junk operands) at that sample index.
  task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int poke,
                       output logic [31:0] res, output logic [4:0] rdo, output logic rw,
                       output int lat, output int busy_cyc, output logic idle_after);
    @(negedge clk);
    funct3 = fn; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    busy_cyc = 0;
    while (1) begin
      if (busy) busy_cyc++;
      start  = (lat == poke);
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      rd_in  = 5'($urandom);
      if (done || lat >= 100) break;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    rdo = rd_out;
    rw  = reg_write;
    @(posedge clk); #1;
    start = 1'b0;
    idle_after = !busy && !done && !reg_write;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_tests++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset reg_write: got %b expected 0", reg_write); end
    n_tests++; if (result !== 32'h0)   begin n_fail++; $display("FAIL reset result: got %h expected 0", result); end
    n_tests++; if (rd_out !== 5'h0)    begin n_fail++; $display("FAIL reset rd_out: got %h expected 0", rd_out); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_fn  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] t_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] t_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'h7FFFFFFC, 32'h00000001, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int          t_lat [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    logic [4:0]  rdo, rd;
    logic        rw, idle;
    int          lat, bc;
    for (int i = 0; i < 12; i++) begin
      rd = (i == 0) ? 5'd5 : 5'(i + 3);
      do_op(t_fn[i], t_a[i], t_b[i], rd, 0, res, rdo, rw, lat, bc, idle);
      n_tests++; if (res !== t_exp[i]) begin n_fail++; $display("FAIL dir[%0d] result: got %h expected %h", i, res, t_exp[i]); end
      n_tests++; if (lat != t_lat[i])  begin n_fail++; $display("FAIL dir[%0d] latency: got %0d expected %0d", i, lat, t_lat[i]); end
      n_tests++; if (bc != t_lat[i])   begin n_fail++; $display("FAIL dir[%0d] busy cycles: got %0d expected %0d", i, bc, t_lat[i]); end
      n_tests++; if (rw !== 1'b1)      begin n_fail++; $display("FAIL dir[%0d] reg_write: got %b expected 1", i, rw); end
      n_tests++; if (rdo !== rd)       begin n_fail++; $display("FAIL dir[%0d] rd_out: got %0d expected %0d", i, rdo, rd); end
      n_tests++; if (idle !== 1'b1)    begin n_fail++; $display("FAIL dir[%0d] idle after done: got %b expected 1", i, idle); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  fn;
    logic [31:0] a, b, res, exp_res;
    logic [4:0]  rd, rdo;
    logic        rw, idle;
    int          lat, bc, sel, exp_lat;
    for (int i = 0; i < 48; i++) begin
      fn  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        4: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      rd = 5'($urandom_range(0, 31));
      exp_res = ref_result(fn, a, b);
      exp_lat = ref_latency(fn, a, b);
      do_op(fn, a, b, rd, 0, res, rdo, rw, lat, bc, idle);
      n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL rnd[%0d] fn=%0d a=%h b=%h result: got %h expected %h", i, fn, a, b, res, exp_res); end
      n_tests++; if (lat != exp_lat)  begin n_fail++; $display("FAIL rnd[%0d] fn=%0d latency: got %0d expected %0d", i, fn, lat, exp_lat); end
      n_tests++; if (rw !== (rd != 0)) begin n_fail++; $display("FAIL rnd[%0d] reg_write: got %b expected %b", i, rw, rd != 0); end
      n_tests++; if (rdo !== rd)      begin n_fail++; $display("FAIL rnd[%0d] rd_out: got %0d expected %0d", i, rdo, rd); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        rw, idle;
    int          lat, bc;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 5, res, rdo, rw, lat, bc, idle);
    n_tests++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL busy_calc result: got %h expected ffffffeb", res); end
    n_tests++; if (lat != 33)            begin n_fail++; $display("FAIL busy_calc latency: got %0d expected 33", lat); end
    n_tests++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL busy_calc idle after: got %b expected 1", idle); end
    do_op(3'd5, 32'hFFFFFFF9, 32'd2, 5'd12, 33, res, rdo, rw, lat, bc, idle);
    n_tests++; if (res !== 32'h7FFFFFFC) begin n_fail++; $display("FAIL busy_done result: got %h expected 7ffffffc", res); end
    n_tests++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL busy_done start ignored: got idle %b expected 1", idle); end
    do_op(3'd4, 32'd5, 32'd0, 5'd3, 1, res, rdo, rw, lat, bc, idle);
    n_tests++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL busy_special result: got %h expected ffffffff", res); end
    n_tests++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL busy_special start ignored: got idle %b expected 1", idle); end
  endtask

  task automatic test_rd_zero();
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        rw, idle;
    int          lat, bc;
    do_op(3'd4, 32'd100, 32'd7, 5'd0, 0, res, rdo, rw, lat, bc, idle);
    n_tests++; if (lat != 33)        begin n_fail++; $display("FAIL rd0 done latency: got %0d expected 33", lat); end
    n_tests++; if (res !== 32'd14)   begin n_fail++; $display("FAIL rd0 result: got %h expected 0000000e", res); end
    n_tests++; if (rw !== 1'b0)      begin n_fail++; $display("FAIL rd0 reg_write: got %b expected 0", rw); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        rw, idle, seen_done;
    int          lat, bc;
    do_op(3'd0, 32'd3, 32'd5, 5'd9, 0, res, rdo, rw, lat, bc, idle);
    n_tests++; if (res !== 32'd15) begin n_fail++; $display("FAIL pre-reset result: got %h expected 0000000f", res); end
    @(negedge clk);
    funct3 = 3'd3; op_a = $urandom; op_b = $urandom; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst busy: got %b expected 0", busy); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL midrst result: got %h expected 0", result); end
    n_tests++; if (rd_out !== 5'h0)  begin n_fail++; $display("FAIL midrst rd_out: got %h expected 0", rd_out); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || reg_write || busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrst activity after reset: got %b expected 0", seen_done); end
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 0, res, rdo, rw, lat, bc, idle);
    n_tests++; if (res !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL postrst result: got %h expected fffffffd", res); end
    n_tests++; if (lat != 33)            begin n_fail++; $display("FAIL postrst latency: got %0d expected 33", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_rd_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read operands (rs1/rs2 data) plus funct3 and destination index.
- Produces a result and a write-enable/index pair that feed the register file write port (WriteData/wr/RegWrite) through the writeback mux.
- Multi-cycle: the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in a cycle where busy=0.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  WIDTH  rs1 data (dividend/multiplicand).
- op_b  input  WIDTH  rs2 data (divisor/multiplier).
- rd_in  input  5  destination register index.
- busy  output  1  high from the cycle after acceptance through the done cycle inclusive.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  final value; valid from the done cycle until the next accepted start.
- rd_out  output  5  captured rd_in; held with result.
- reg_write  output  1  equals done AND (rd_out != 0); register x0 is never written.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; busy, done, reg_write, result and rd_out all become 0.
  - Any operation in flight is abandoned with no done pulse.
  - rst has priority over start in the same cycle.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches funct3, op_a, op_b, rd_in and computes operand magnitudes/sign flags.
  - Next state is CALC, or DONE directly for special cases.
- CALC:
  - Exactly WIDTH cycles, driven by a counter counting WIDTH-1 down to 0, one bit per cycle.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
  - Next state is DONE when the counter reaches 0.
- DONE:
  - One cycle: done=1, result driven, reg_write as defined in Ports.
  - Next state is IDLE. A start seen in the DONE cycle is ignored because busy=1.
- Latency, with acceptance at edge N:
  - Normal ops: done is high in the cycle after edge N+WIDTH+1, i.e. 33 cycles after acceptance for WIDTH=32.
  - Special cases: done is high in the cycle after edge N+1.
  - Accepting back-to-back ops requires one idle cycle between done and the next start.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Sign fix-up:
  - Product is negated when exactly one signed operand is negative.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result select:
  - MUL returns product[WIDTH-1:0]; MULH/MULHSU/MULHU return product[2WIDTH-1:WIDTH].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (fast path, no CALC):
  - Divide by zero: quotient = all ones for both DIV and DIVU; remainder = op_a.
  - Signed overflow (DIV/REM with op_a = most negative value and op_b = -1): quotient = op_a, remainder = 0.
- Input isolation: op_a, op_b, funct3 and rd_in may change freely after acceptance; the unit uses only the latched copies.
- Output stability: result and rd_out hold their value after done until the next accepted start or reset. done and reg_write are 0 outside the DONE cycle.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), rd=5 -> done exactly 33 cycles after the start cycle; result 0xFFFFFFEB; reg_write=1; rd_out=5.
- Upper-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM with the same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 / 2 -> 1.
- Special cases (each with done in the cycle after acceptance, busy high for 1 cycle):
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake and x0 suppression:
  - Start pulsed while busy, with different operands -> ignored; first result is unchanged.
  - Op with rd=0 -> done=1, reg_write=0.
- Reset mid-operation:
  - rst=1 for one cycle 10 cycles into CALC -> next cycle busy=0, result=0, no done pulse.
  - A new start after reset completes with the correct result.
